// File: rtl/mm_order_scheduler_pkg.sv
// Shared types and price helpers for the market-making order scheduler.
// Price and position widths are fixed here and sized for the whole slice.
package mm_pkg;

    localparam int PRICE_W = 8;
    localparam int POS_W   = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        COOLDOWN
    } state_t;

    typedef enum logic {
        BUY  = 1'b0,
        SELL = 1'b1
    } side_t;

    typedef logic [PRICE_W-1:0]        price_t;
    typedef logic signed [POS_W-1:0]   pos_t;

    // Ask price: mid plus offset, clamped at the top of the price range.
    function automatic price_t price_sat_add(input price_t a, input price_t b);
        logic [PRICE_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[PRICE_W] ? '1 : sum[PRICE_W-1:0];
    endfunction

    // Bid price: mid minus offset, clamped at zero.
    function automatic price_t price_sat_sub(input price_t a, input price_t b);
        return (a < b) ? '0 : price_t'(a - b);
    endfunction

endpackage

// File: rtl/mm_order_scheduler_if.sv
// Order/ack channel between the scheduler (master) and the exchange (slave).
interface mm_order_scheduler_if
    import mm_pkg::*;
();

    logic   ord_valid;
    logic   ord_ready;
    side_t  ord_side;
    price_t ord_price;
    logic   ack_valid;
    logic   ack_filled;

    modport master (
        output ord_valid, ord_side, ord_price,
        input  ord_ready, ack_valid, ack_filled
    );

    modport slave (
        input  ord_valid, ord_side, ord_price,
        output ord_ready, ack_valid, ack_filled
    );

endinterface

// File: rtl/mm_side_arbiter.sv
// Inventory-gated eligibility and round-robin side pick for a new order.
// When both sides qualify, the side opposite the last granted one wins.
module mm_side_arbiter
    import mm_pkg::*;
#(
    parameter int POS_LIMIT = 16
) (
    input  logic  buy_req,
    input  logic  sell_req,
    input  pos_t  position,
    input  side_t last_side,
    output logic  grant,
    output side_t side
);

    localparam pos_t LIMIT = pos_t'(POS_LIMIT);

    logic buy_ok;
    logic sell_ok;

    // Eligibility against the signed inventory window, then side choice.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        buy_ok  = buy_req  && (position < LIMIT);
        sell_ok = sell_req && (position > -LIMIT);
        grant   = buy_ok || sell_ok;
        side    = BUY;
        if (buy_ok && sell_ok) begin
            side = (last_side == SELL) ? BUY : SELL;
        end else if (sell_ok) begin
            side = SELL;
        end
    end

endmodule

// File: rtl/mm_order_scheduler.sv
// Market-making order scheduler: picks a side, prices off mid +/- half-spread,
// offers one order at a time, waits for ack or timeout, then cools down.
// The state named COOLDOWN is written mm_pkg::COOLDOWN because the cooldown
// length parameter shares its name.
module mm_order_scheduler
    import mm_pkg::*;
#(
    parameter int     POS_LIMIT   = 16,
    parameter price_t HALF_SPREAD = 8'h08,
    parameter int     COOLDOWN    = 4,
    parameter int     ACK_TIMEOUT = 32
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   enable,
    input  logic   buy_req,
    input  logic   sell_req,
    input  price_t mid_price,
    mm_order_scheduler_if.master ord,
    output pos_t   position,
    output logic   busy,
    output logic   timeout_pulse
);

    localparam int TO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int CD_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [CD_W-1:0] CD_LAST = CD_W'((COOLDOWN > 0) ? COOLDOWN - 1 : 0);
    // With no cooldown the order completes straight back into IDLE.
    localparam state_t AFTER_ORDER = (COOLDOWN == 0) ? IDLE : mm_pkg::COOLDOWN;

    state_t            state;
    state_t            state_next;
    side_t             last_side;
    side_t             side_q;
    side_t             arb_side;
    price_t            price_q;
    logic              arb_grant;
    logic [TO_W-1:0]   to_cnt;
    logic [CD_W-1:0]   cd_cnt;
    logic              start;
    logic              accept;
    logic              ack_take;
    logic              expire;

    mm_side_arbiter #(
        .POS_LIMIT (POS_LIMIT)
    ) u_arbiter (
        .buy_req   (buy_req),
        .sell_req  (sell_req),
        .position  (position),
        .last_side (last_side),
        .grant     (arb_grant),
        .side      (arb_side)
    );

    assign ord.ord_valid = (state == ISSUE);
    assign ord.ord_side  = side_q;
    assign ord.ord_price = price_q;
    assign busy          = (state != IDLE);

    // Next-state decode and the single-cycle event strobes that drive the datapath.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        accept     = 1'b0;
        ack_take   = 1'b0;
        expire     = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable && arb_grant) begin
                    start      = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (ord.ord_ready) begin
                    accept     = 1'b1;
                    state_next = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                // An ack on the expiry cycle wins over the timeout.
                if (ord.ack_valid) begin
                    ack_take   = 1'b1;
                    state_next = AFTER_ORDER;
                end else if (to_cnt == TO_LAST) begin
                    expire     = 1'b1;
                    state_next = AFTER_ORDER;
                end
            end
            mm_pkg::COOLDOWN: begin
                if (cd_cnt == CD_LAST) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Order latch, round-robin history, inventory, timeout and cooldown counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            side_q        <= BUY;
            price_q       <= '0;
            last_side     <= SELL;
            position      <= '0;
            timeout_pulse <= 1'b0;
            to_cnt        <= '0;
            cd_cnt        <= '0;
        end else begin
            timeout_pulse <= expire;

            if (start) begin
                side_q    <= arb_side;
                last_side <= arb_side;
                price_q   <= (arb_side == BUY) ? price_sat_sub(mid_price, HALF_SPREAD)
                                               : price_sat_add(mid_price, HALF_SPREAD);
            end

            if (accept) begin
                to_cnt <= '0;
            end else if (state == WAIT_ACK) begin
                to_cnt <= to_cnt + 1'b1;
            end

            if (ack_take && ord.ack_filled) begin
                position <= (side_q == BUY) ? position + pos_t'(1) : position - pos_t'(1);
            end

            if (state == mm_pkg::COOLDOWN) begin
                cd_cnt <= cd_cnt + 1'b1;
            end else begin
                cd_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mm_order_scheduler.sv
// Self-checking bench for mm_order_scheduler: directed scenarios plus random
// orders, all compared against a transaction-level model of inventory,
// round-robin history and pricing.
module tb_mm_order_scheduler;

    localparam int LIM       = 2;
    localparam int CD_CYCLES = 4;
    localparam int TO_CYCLES = 32;
    localparam int SPREAD    = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic              buy_req;
    logic              sell_req;
    logic [7:0]        mid_price;
    logic signed [7:0] position;
    logic              busy;
    logic              timeout_pulse;

    mm_order_scheduler_if bus ();

    mm_order_scheduler #(
        .POS_LIMIT   (LIM),
        .HALF_SPREAD (8'h08),
        .COOLDOWN    (CD_CYCLES),
        .ACK_TIMEOUT (TO_CYCLES)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .buy_req       (buy_req),
        .sell_req      (sell_req),
        .mid_price     (mid_price),
        .ord           (bus),
        .position      (position),
        .busy          (busy),
        .timeout_pulse (timeout_pulse)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: net inventory and the side of the last order started.
    int m_pos  = 0;
    int m_last = 1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Count cooldown cycles until busy falls; the first cycle may carry the timeout pulse.
    task automatic wait_cooldown(input bit exp_to);
        int count;
        count = 0;
        while (busy && count < 50) begin
            check("timeout_pulse_cd", int'(timeout_pulse), (count == 0 && exp_to) ? 1 : 0);
            // A stray ack outside WAIT_ACK must change nothing.
            bus.ack_valid  = (count == 0);
            bus.ack_filled = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus.ack_valid = 1'b0;
            count++;
        end
        check("cooldown_len", count, CD_CYCLES);
        check("pos_after_cd", int'(position), m_pos);
        check("timeout_pulse_idle", int'(timeout_pulse), 0);
    endtask

    // One strategy request from IDLE; expectations come from the model rules.
    task automatic do_order(input bit buy, input bit sell, input logic [7:0] mid, input bit en,
                            input bit en_wait, input int rdy_dly, input bit timeout,
                            input int ack_dly, input bit fill);
        bit b_ok, s_ok;
        int exp_side, exp_price, m;
        buy_req   = buy;
        sell_req  = sell;
        mid_price = mid;
        enable    = en;
        b_ok = buy  && (m_pos < LIM);
        s_ok = sell && (m_pos > -LIM);
        if (!en || !(b_ok || s_ok)) begin
            repeat (3) begin
                @(posedge clk);
                @(negedge clk);
                check("blocked_valid", int'(bus.ord_valid), 0);
                check("blocked_busy", int'(busy), 0);
            end
            buy_req  = 1'b0;
            sell_req = 1'b0;
            enable   = 1'b1;
            return;
        end
        exp_side = (b_ok && s_ok) ? ((m_last == 1) ? 0 : 1) : (s_ok ? 1 : 0);
        m_last   = exp_side;
        m        = int'(mid);
        if (exp_side == 0) exp_price = (m < SPREAD) ? 0 : m - SPREAD;
        else               exp_price = (m + SPREAD > 255) ? 255 : m + SPREAD;

        @(posedge clk);
        @(negedge clk);
        check("valid_latency", int'(bus.ord_valid), 1);
        check("ord_side", int'(bus.ord_side), exp_side);
        check("ord_price", int'(bus.ord_price), exp_price);
        check("busy_issue", int'(busy), 1);

        // Backpressure: inputs wander, a stray ack arrives; the offer must hold.
        for (int i = 0; i < rdy_dly; i++) begin
            mid_price      = 8'($urandom_range(0, 255));
            buy_req        = 1'($urandom_range(0, 1));
            sell_req       = 1'($urandom_range(0, 1));
            bus.ack_valid  = (i == 0);
            bus.ack_filled = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus.ack_valid = 1'b0;
            check("hold_valid", int'(bus.ord_valid), 1);
            check("hold_side", int'(bus.ord_side), exp_side);
            check("hold_price", int'(bus.ord_price), exp_price);
            check("hold_pos", int'(position), m_pos);
        end

        bus.ord_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.ord_ready = 1'b0;
        buy_req       = 1'b0;
        sell_req      = 1'b0;
        enable        = en_wait;
        check("valid_drop", int'(bus.ord_valid), 0);
        check("busy_wait", int'(busy), 1);

        if (timeout) begin
            repeat (TO_CYCLES) begin
                check("no_early_pulse", int'(timeout_pulse), 0);
                @(posedge clk);
                @(negedge clk);
            end
        end else begin
            repeat (ack_dly - 1) begin
                check("no_pulse_wait", int'(timeout_pulse), 0);
                @(posedge clk);
                @(negedge clk);
            end
            bus.ack_valid  = 1'b1;
            bus.ack_filled = fill;
            @(posedge clk);
            @(negedge clk);
            bus.ack_valid = 1'b0;
            if (fill) m_pos += (exp_side == 0) ? 1 : -1;
        end
        check("pos_after_ack", int'(position), m_pos);
        wait_cooldown(timeout);
        enable = 1'b1;
    endtask

    initial begin
        bit pick_buy;
        reset          = 1'b1;
        enable         = 1'b0;
        buy_req        = 1'b0;
        sell_req       = 1'b0;
        mid_price      = 8'h00;
        bus.ord_ready  = 1'b0;
        bus.ack_valid  = 1'b0;
        bus.ack_filled = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", int'(bus.ord_valid), 0);
        check("rst_side", int'(bus.ord_side), 0);
        check("rst_price", int'(bus.ord_price), 0);
        check("rst_pos", int'(position), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_pulse", int'(timeout_pulse), 0);
        reset = 1'b0;
        @(negedge clk);

        // Enable low blocks a valid request.
        do_order(1, 0, 8'h80, 0, 1, 0, 0, 1, 1);
        // Basic buy, ack filled after 3 cycles.
        do_order(1, 0, 8'h80, 1, 1, 0, 0, 3, 1);
        // Bid clamps at zero, with 10 cycles of backpressure.
        do_order(1, 0, 8'h04, 1, 1, 10, 0, 2, 0);
        // Ask clamps at full scale.
        do_order(0, 1, 8'hFC, 1, 1, 1, 0, 1, 0);
        // Contention alternates sides.
        repeat (4) do_order(1, 1, 8'h60, 1, 1, 0, 0, 1, 1);
        // Inventory limit: buys stop at +LIM, then a sell goes through.
        repeat (3) do_order(1, 0, 8'h50, 1, 1, 0, 0, 1, 1);
        do_order(0, 1, 8'h50, 1, 1, 0, 0, 1, 1);
        // Timeout with no ack, then an ack on the expiry cycle.
        do_order(0, 1, 8'h40, 1, 1, 0, 1, 0, 0);
        do_order(0, 1, 8'h40, 1, 1, 0, 0, TO_CYCLES, 1);
        // Enable dropped while waiting for the ack.
        do_order(1, 0, 8'h30, 1, 0, 2, 0, 4, 1);

        for (int n = 0; n < 80; n++) begin
            bit t;
            t = ($urandom_range(0, 7) == 0);
            do_order(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     8'($urandom_range(0, 255)), ($urandom_range(0, 7) != 0),
                     1'($urandom_range(0, 1)), $urandom_range(0, 3), t,
                     ($urandom_range(0, 5) == 0) ? TO_CYCLES : $urandom_range(1, 6),
                     1'($urandom_range(0, 1)));
        end

        // Reset in the middle of ISSUE clears outputs at once.
        pick_buy = (m_pos < LIM);
        buy_req  = pick_buy;
        sell_req = !pick_buy;
        enable   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("pre_rst_valid", int'(bus.ord_valid), 1);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", int'(bus.ord_valid), 0);
        check("mid_rst_pos", int'(position), 0);
        check("mid_rst_busy", int'(busy), 0);
        m_pos  = 0;
        m_last = 1;
        @(negedge clk);
        reset    = 1'b0;
        buy_req  = 1'b0;
        sell_req = 1'b0;
        check("post_rst_side", int'(bus.ord_side), 0);
        check("post_rst_price", int'(bus.ord_price), 0);
        // First contested grant after reset goes to buy again.
        do_order(1, 1, 8'h90, 1, 1, 0, 0, 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
